// File: rtl/fifo_consumer_pkg.sv
// ---------------------------------------------------------------------------
// fifo_consumer_pkg
//
// Shared definitions for the multi-channel FIFO read-side consumer:
//   - default sizing for the consumer (word width, channel count, burst
//     length, local buffer depth)
//   - the consumer FSM state type
//   - the buffer entry layout (data word plus source channel tag) at the
//     default sizing, for sinks that unpack entries of a default consumer
//   - a small helper for round-robin pointer rotation
// ---------------------------------------------------------------------------
package fifo_consumer_pkg;

  localparam int DEF_WIDTH     = 1024;
  localparam int DEF_NCH       = 4;
  localparam int DEF_BURST     = 8;
  localparam int DEF_BUF_DEPTH = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARB   = 2'd1,
    BURST = 2'd2
  } cons_state_t;

  typedef struct packed {
    logic [DEF_WIDTH-1:0]       data;
    logic [$clog2(DEF_NCH)-1:0] chan;
  } buf_entry_t;

  // Channel that follows 'chan' in round-robin order among 'nch' channels.
  function automatic int next_chan(input int chan, input int nch);
    return (chan + 1 >= nch) ? 0 : chan + 1;
  endfunction

endpackage

// File: rtl/fifo_consumer_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
//
// Combinational rotating-priority arbiter. The search starts at channel 'ptr'
// and walks upward (wrapping at NCH); the first requesting channel wins.
//
// Ports:
//   req        in   NCH          request vector (one bit per channel)
//   ptr        in   $clog2(NCH)  highest-priority channel this cycle
//   grant      out  NCH          one-hot grant, all zero when nobody requests
//   grant_idx  out  $clog2(NCH)  binary index of the granted channel
//   any        out  1            at least one request present
// ---------------------------------------------------------------------------
module rr_arbiter #(
  parameter int NCH = 4
) (
  input  logic [NCH-1:0]         req,
  input  logic [$clog2(NCH)-1:0] ptr,
  output logic [NCH-1:0]         grant,
  output logic [$clog2(NCH)-1:0] grant_idx,
  output logic                   any
);

  localparam int CHW = $clog2(NCH);

  int             idx;
  logic [CHW-1:0] sel;

  // Scan NCH positions starting at ptr; once a winner is found the 'any'
  // flag masks every later candidate, so the grant stays one-hot.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    idx       = 0;
    sel       = '0;
    for (int i = 0; i < NCH; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NCH) idx = idx - NCH;
      sel = CHW'(idx);
      if (!any && req[sel]) begin
        any        = 1'b1;
        grant[sel] = 1'b1;
        grant_idx  = sel;
      end
    end
  end

endmodule

// File: rtl/fifo_consumer_rr.sv
// ---------------------------------------------------------------------------
// fifo_consumer_rr
//
// Read-side consumer for NCH async FIFOs, all in the read clock domain clk2.
// A round-robin arbiter picks a non-empty FIFO, then up to BURST reads are
// issued to it back to back. Each read word arrives one cycle after its Read
// pulse and is stored, tagged with its channel, in a BUF_DEPTH-entry circular
// buffer. The buffer head is offered to a sink through a valid/ready port.
// Reads are only issued while the buffer has room for everything already
// requested (credit), so the buffer can never overflow.
//
// Optional feature (macro CONSUMER_CHKSUM_EN): adds output Chksum, a running
// XOR of every word handed to the sink. Without the macro neither the port
// nor the checksum register exist.
//
// Ports:
//   clk2       in   1                     read-domain clock
//   rst2       in   1                     synchronous reset, active-high
//   Data_out   in   NCH*WIDTH             FIFO read data, channel k at
//                                         [k*WIDTH +: WIDTH], valid one cycle
//                                         after Read[k]
//   Empty      in   NCH                   per-FIFO empty flag
//   Read       out  NCH                   per-FIFO read enable, one-hot or 0
//   Rd_data    out  WIDTH                 word at the buffer head (0 if none)
//   Rd_chan    out  $clog2(NCH)           source channel of Rd_data
//   Rd_valid   out  1                     buffer non-empty
//   Rd_ready   in   1                     sink accepts the head word
//   Buf_count  out  $clog2(BUF_DEPTH)+1   entries held in the buffer
//   Chksum     out  WIDTH                 (CONSUMER_CHKSUM_EN only)
// ---------------------------------------------------------------------------
module fifo_consumer_rr
  import fifo_consumer_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int NCH       = DEF_NCH,
  parameter int BURST     = DEF_BURST,
  parameter int BUF_DEPTH = DEF_BUF_DEPTH
) (
  input  logic                         clk2,
  input  logic                         rst2,
  input  logic [NCH*WIDTH-1:0]         Data_out,
  input  logic [NCH-1:0]               Empty,
  output logic [NCH-1:0]               Read,
  output logic [WIDTH-1:0]             Rd_data,
  output logic [$clog2(NCH)-1:0]       Rd_chan,
  output logic                         Rd_valid,
  input  logic                         Rd_ready,
  output logic [$clog2(BUF_DEPTH):0]   Buf_count
`ifdef CONSUMER_CHKSUM_EN
  ,
  output logic [WIDTH-1:0]             Chksum
`endif
);

  localparam int CHW = $clog2(NCH);
  localparam int AW  = $clog2(BUF_DEPTH);
  localparam int BCW = $clog2(BURST + 1);

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [CHW-1:0]   chan;
  } entry_t;

  // FSM and grant bookkeeping
  cons_state_t    state;
  cons_state_t    state_next;
  logic [NCH-1:0] grant_oh_q;
  logic [CHW-1:0] grant_q;
  logic [CHW-1:0] rr_ptr;
  logic [BCW-1:0] burst_cnt;

  // Arbiter results
  logic [NCH-1:0] arb_grant;
  logic [CHW-1:0] arb_idx;
  logic           arb_any;

  // Read issue / capture
  logic           inflight;
  logic [CHW-1:0] inflight_chan;
  logic           grant_empty;
  logic           credit;
  logic           read_en;
  logic           burst_last;
  logic [AW+1:0]  occupancy;
  logic [WIDTH-1:0] ch_data [NCH];

  // Circular buffer; pointers carry an extra wrap bit so full and empty
  // are distinguishable without a separate counter.
  entry_t         mem [BUF_DEPTH];
  entry_t         head;
  logic [AW:0]    wptr;
  logic [AW:0]    rptr;
  logic           push;
  logic           pop;

  rr_arbiter #(
    .NCH (NCH)
  ) u_arb (
    .req       (~Empty),
    .ptr       (rr_ptr),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .any       (arb_any)
  );

  // Credit counts the word already requested but not yet captured, so a
  // read issued now can never find the buffer full when its data arrives.
  // The enum literal is qualified because the BURST parameter shadows it.
  always_comb begin
    occupancy   = {1'b0, Buf_count} + (AW+2)'(inflight);
    credit      = occupancy < (AW+2)'(BUF_DEPTH);
    grant_empty = |(grant_oh_q & Empty);
    read_en     = (state == fifo_consumer_pkg::BURST) && !grant_empty && credit;
    burst_last  = read_en && (burst_cnt == BCW'(BURST - 1));
  end

  // FSM state register
  always_ff @(posedge clk2) begin
    if (rst2) state <= IDLE;
    else      state <= state_next;
  end

  // FSM next state: a burst ends on its last read, or as soon as a read
  // cannot be issued (channel drained or no credit), handing back to ARB.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:  if (!(&Empty)) state_next = ARB;
      ARB:   state_next = arb_any ? fifo_consumer_pkg::BURST : IDLE;
      fifo_consumer_pkg::BURST:
             if (!read_en || burst_last) state_next = ARB;
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs: Read mirrors the registered one-hot grant only on cycles
  // where a read is actually allowed.
  always_comb begin
    Read = read_en ? grant_oh_q : '0;
    push = inflight;
    pop  = Rd_valid && Rd_ready;
  end

  // Grant, burst counter, rotating pointer and in-flight tracking
  always_ff @(posedge clk2) begin
    if (rst2) begin
      grant_oh_q    <= '0;
      grant_q       <= '0;
      rr_ptr        <= '0;
      burst_cnt     <= '0;
      inflight      <= 1'b0;
      inflight_chan <= '0;
    end else begin
      inflight      <= read_en;
      inflight_chan <= grant_q;
      if (state == ARB && arb_any) begin
        grant_oh_q <= arb_grant;
        grant_q    <= arb_idx;
        burst_cnt  <= '0;
      end
      if (read_en) burst_cnt <= burst_cnt + 1'b1;
      if (state == fifo_consumer_pkg::BURST && (!read_en || burst_last))
        rr_ptr <= CHW'(next_chan(int'(grant_q), NCH));
    end
  end

  // Per-channel view of the packed FIFO data bus
  always_comb begin
    for (int k = 0; k < NCH; k++) ch_data[k] = Data_out[k*WIDTH +: WIDTH];
  end

  // Buffer storage; contents need no reset because nothing is visible
  // unless the pointers say the slot is occupied.
  always_ff @(posedge clk2) begin
    if (push) mem[wptr[AW-1:0]] <= '{data: ch_data[inflight_chan], chan: inflight_chan};
  end

  // Buffer pointers; a capture and a drain in the same cycle move both
  always_ff @(posedge clk2) begin
    if (rst2) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
    end
  end

  // Head presentation; gated to zero while empty so stale slots never leak
  always_comb begin
    head      = mem[rptr[AW-1:0]];
    Buf_count = wptr - rptr;
    Rd_valid  = (wptr != rptr);
    Rd_data   = Rd_valid ? head.data : '0;
    Rd_chan   = Rd_valid ? head.chan : '0;
  end

`ifdef CONSUMER_CHKSUM_EN
  // Running XOR of every word the sink accepts
  always_ff @(posedge clk2) begin
    if (rst2)     Chksum <= '0;
    else if (pop) Chksum <= Chksum ^ Rd_data;
  end
`endif

endmodule

// File: tb/tb_fifo_consumer_rr.sv
// ---------------------------------------------------------------------------
// tb_fifo_consumer_rr
//
// Bench for fifo_consumer_rr with 4 channels of 16-bit words, BURST=2 and a
// 16-entry buffer. A behavioural FIFO per channel answers Read pulses; every
// loaded word is also pushed to a per-channel expected queue and popped when
// the sink side accepts a word from that channel.
// ---------------------------------------------------------------------------
module tb_fifo_consumer_rr;

  localparam int W = 16;
  localparam int N = 4;
  localparam int B = 2;
  localparam int D = 16;

  logic           clk2 = 1'b0;
  logic           rst2 = 1'b1;
  logic [N*W-1:0] Data_out = '0;
  logic [N-1:0]   Empty = '1;
  logic [N-1:0]   Read;
  logic [W-1:0]   Rd_data;
  logic [1:0]     Rd_chan;
  logic           Rd_valid;
  logic           Rd_ready = 1'b0;
  logic [4:0]     Buf_count;
`ifdef CONSUMER_CHKSUM_EN
  logic [W-1:0]   Chksum;
`endif

  typedef struct packed {
    logic [1:0]   chan;
    logic [W-1:0] data;
  } out_t;

  logic [W-1:0] fifo_q [N][$];
  logic [W-1:0] exp_q  [N][$];
  out_t         out_q  [$];
  int           read_log [$];
  int           empty_viol = 0;
  int           onehot_viol = 0;
  int           n_checks = 0;
  int           n_pass = 0;

  fifo_consumer_rr #(
    .WIDTH     (W),
    .NCH       (N),
    .BURST     (B),
    .BUF_DEPTH (D)
  ) dut (
    .clk2      (clk2),
    .rst2      (rst2),
    .Data_out  (Data_out),
    .Empty     (Empty),
    .Read      (Read),
    .Rd_data   (Rd_data),
    .Rd_chan   (Rd_chan),
    .Rd_valid  (Rd_valid),
    .Rd_ready  (Rd_ready),
    .Buf_count (Buf_count)
`ifdef CONSUMER_CHKSUM_EN
    ,
    .Chksum    (Chksum)
`endif
  );

  always #5 clk2 = ~clk2;

  // FIFO model: a Read seen at the edge pops one word, which is presented on
  // Data_out for the following cycle; Empty follows the queue occupancy.
  logic [N-1:0] rd_snap;
  always @(posedge clk2) begin
    rd_snap = Read;
    #1;
    for (int k = 0; k < N; k++) begin
      if (rd_snap[k] && fifo_q[k].size() > 0) Data_out[k*W +: W] = fifo_q[k].pop_front();
      Empty[k] = (fifo_q[k].size() == 0);
    end
  end

  // Monitor: log reads, protocol violations and accepted words
  always @(negedge clk2) begin
    if (!rst2) begin
      if (Read != '0) begin
        if (!$onehot(Read)) onehot_viol++;
        if ((Read & Empty) != '0) empty_viol++;
        for (int k = 0; k < N; k++) if (Read[k]) read_log.push_back(k);
      end
      if (Rd_valid && Rd_ready) out_q.push_back({Rd_chan, Rd_data});
    end
  end

  task automatic load(input int ch, input logic [W-1:0] w);
    fifo_q[ch].push_back(w);
    exp_q[ch].push_back(w);
  endtask

  task automatic clear_all();
    for (int k = 0; k < N; k++) begin
      fifo_q[k].delete();
      exp_q[k].delete();
    end
    out_q.delete();
    read_log.delete();
  endtask

  task automatic do_reset();
    @(posedge clk2); #2;
    rst2 = 1'b1;
    clear_all();
    repeat (3) @(posedge clk2);
    #2;
    rst2 = 1'b0;
  endtask

  task automatic wait_out(input int n, input int budget);
    for (int i = 0; i < budget && out_q.size() < n; i++) @(posedge clk2);
    @(negedge clk2);
  endtask

  task automatic test_reset();
    out_t e;
    for (int k = 0; k < N; k++) load(k, W'(16'h1000 + k));
    repeat (2) @(posedge clk2);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk2);
      n_checks++;
      if (Read !== 4'b0000) $display("[TB] FAIL reset_read: got %b, expected 0000", Read);
      else n_pass++;
      n_checks++;
      if (Rd_valid !== 1'b0) $display("[TB] FAIL reset_valid: got %b, expected 0", Rd_valid);
      else n_pass++;
      n_checks++;
      if (Buf_count !== 5'd0) $display("[TB] FAIL reset_count: got %0d, expected 0", Buf_count);
      else n_pass++;
    end
    n_checks++;
    if (Rd_data !== '0) $display("[TB] FAIL reset_data: got %h, expected 0", Rd_data);
    else n_pass++;
    e = '0;
    clear_all();
    repeat (3) @(posedge clk2);
    #2;
    rst2 = 1'b0;
  endtask

  task automatic test_single_channel();
    out_t e;
    logic [W-1:0] x;
    Rd_ready = 1'b1;
    load(1, 16'hC001);
    load(1, 16'hC002);
    load(1, 16'hC003);
    wait_out(3, 80);
    n_checks++;
    if (out_q.size() != 3) $display("[TB] FAIL single_count: got %0d words, expected 3", out_q.size());
    else n_pass++;
    n_checks++;
    if (read_log.size() != 3) $display("[TB] FAIL single_reads: got %0d reads, expected 3", read_log.size());
    else n_pass++;
    foreach (read_log[i]) begin
      n_checks++;
      if (read_log[i] != 1) $display("[TB] FAIL single_read_chan: got %0d, expected 1", read_log[i]);
      else n_pass++;
    end
    while (out_q.size() > 0) begin
      e = out_q.pop_front();
      x = (exp_q[1].size() > 0) ? exp_q[1].pop_front() : 'x;
      n_checks++;
      if (e.chan !== 2'd1 || e.data !== x)
        $display("[TB] FAIL single_data: got ch%0d %h, expected ch1 %h", e.chan, e.data, x);
      else n_pass++;
    end
    repeat (3) @(posedge clk2);
    @(negedge clk2);
    n_checks++;
    if (Buf_count !== 5'd0) $display("[TB] FAIL single_drained: got %0d, expected 0", Buf_count);
    else n_pass++;
  endtask

  task automatic test_round_robin();
    int   exp_order [12] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 1, 2, 3};
    out_t e;
    logic [W-1:0] x;
    do_reset();
    Rd_ready = 1'b1;
    for (int k = 0; k < N; k++)
      for (int i = 0; i < 3; i++) load(k, W'(16'h2000 + k*16 + i));
    wait_out(12, 200);
    n_checks++;
    if (read_log.size() != 12) $display("[TB] FAIL rr_reads: got %0d reads, expected 12", read_log.size());
    else n_pass++;
    for (int i = 0; i < 12 && i < read_log.size(); i++) begin
      n_checks++;
      if (read_log[i] != exp_order[i])
        $display("[TB] FAIL rr_order[%0d]: got ch%0d, expected ch%0d", i, read_log[i], exp_order[i]);
      else n_pass++;
    end
    while (out_q.size() > 0) begin
      e = out_q.pop_front();
      x = (exp_q[e.chan].size() > 0) ? exp_q[e.chan].pop_front() : 'x;
      n_checks++;
      if (e.data !== x) $display("[TB] FAIL rr_data: ch%0d got %h, expected %h", e.chan, e.data, x);
      else n_pass++;
    end
  endtask

  task automatic test_back_pressure();
    out_t e;
    logic [W-1:0] x;
    logic [W-1:0] head;
    do_reset();
    Rd_ready = 1'b0;
    for (int k = 0; k < N; k++)
      for (int i = 0; i < 6; i++) load(k, W'(16'hB000 + k*256 + i));
    head = exp_q[0][0];
    repeat (60) @(posedge clk2);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk2);
      n_checks++;
      if (read_log.size() != 16) $display("[TB] FAIL bp_reads: got %0d reads, expected 16", read_log.size());
      else n_pass++;
      n_checks++;
      if (Read !== 4'b0000) $display("[TB] FAIL bp_read_idle: got %b, expected 0000", Read);
      else n_pass++;
      n_checks++;
      if (Buf_count !== 5'd16) $display("[TB] FAIL bp_count: got %0d, expected 16", Buf_count);
      else n_pass++;
      n_checks++;
      if (Rd_valid !== 1'b1 || Rd_chan !== 2'd0 || Rd_data !== head)
        $display("[TB] FAIL bp_head_hold: got v%b ch%0d %h, expected v1 ch0 %h", Rd_valid, Rd_chan, Rd_data, head);
      else n_pass++;
      repeat (3) @(posedge clk2);
    end
    #2;
    Rd_ready = 1'b1;
    wait_out(24, 300);
    n_checks++;
    if (out_q.size() != 24 || read_log.size() != 24)
      $display("[TB] FAIL bp_resume: got %0d words %0d reads, expected 24 24", out_q.size(), read_log.size());
    else n_pass++;
    while (out_q.size() > 0) begin
      e = out_q.pop_front();
      x = (exp_q[e.chan].size() > 0) ? exp_q[e.chan].pop_front() : 'x;
      n_checks++;
      if (e.data !== x) $display("[TB] FAIL bp_data: ch%0d got %h, expected %h", e.chan, e.data, x);
      else n_pass++;
    end
  endtask

  task automatic test_wrap();
    out_t e;
    logic [W-1:0] x;
    int counts [N] = '{5, 4, 3, 1};
    read_log.delete();
    for (int k = 0; k < N; k++)
      for (int i = 0; i < counts[k]; i++) load(k, W'(16'h5000 + k*256 + i));
    for (int c = 0; c < 400 && out_q.size() < 13; c++) begin
      @(posedge clk2); #2;
      Rd_ready = 1'($urandom_range(0, 1));
    end
    #2;
    Rd_ready = 1'b1;
    repeat (4) @(posedge clk2);
    @(negedge clk2);
    n_checks++;
    if (out_q.size() != 13) $display("[TB] FAIL wrap_count: got %0d words, expected 13", out_q.size());
    else n_pass++;
    n_checks++;
    if (empty_viol != 0) $display("[TB] FAIL no_empty_read: got %0d violations, expected 0", empty_viol);
    else n_pass++;
    n_checks++;
    if (onehot_viol != 0) $display("[TB] FAIL read_onehot: got %0d violations, expected 0", onehot_viol);
    else n_pass++;
    while (out_q.size() > 0) begin
      e = out_q.pop_front();
      x = (exp_q[e.chan].size() > 0) ? exp_q[e.chan].pop_front() : 'x;
      n_checks++;
      if (e.data !== x) $display("[TB] FAIL wrap_data: ch%0d got %h, expected %h", e.chan, e.data, x);
      else n_pass++;
    end
    n_checks++;
    if (Buf_count !== 5'd0 || Rd_valid !== 1'b0)
      $display("[TB] FAIL wrap_drained: got count %0d valid %b, expected 0 0", Buf_count, Rd_valid);
    else n_pass++;
  endtask

`ifdef CONSUMER_CHKSUM_EN
  task automatic test_chksum();
    do_reset();
    Rd_ready = 1'b1;
    load(0, 16'h00A5);
    load(0, 16'h000F);
    load(0, 16'h00FF);
    wait_out(3, 80);
    repeat (2) @(posedge clk2);
    @(negedge clk2);
    n_checks++;
    if (Chksum !== 16'h0055) $display("[TB] FAIL chksum_value: got %h, expected 0055", Chksum);
    else n_pass++;
    @(posedge clk2); #2;
    rst2 = 1'b1;
    @(negedge clk2);
    n_checks++;
    if (Chksum !== 16'h0000) $display("[TB] FAIL chksum_reset: got %h, expected 0000", Chksum);
    else n_pass++;
    @(posedge clk2); #2;
    rst2 = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_single_channel();
    test_round_robin();
    test_back_pressure();
    test_wrap();
`ifdef CONSUMER_CHKSUM_EN
    test_chksum();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
